// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low button pins in, conditioned
// level and strobe vectors out, one bit per key channel.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] KEY_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic [NUM_KEYS-1:0] key_step;

    // Board side: drives the pins, consumes the strobes.
    modport master (
        output KEY_n,
        input  key_level, key_press, key_release, key_repeat, key_step
    );

    // Conditioner side.
    modport slave (
        input  KEY_n,
        output key_level, key_press, key_release, key_repeat, key_step
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key input conditioning: 2-flop synchronizer, debounce counter,
// registered press/release strobes and an auto-repeat FSM producing
// key_repeat and the key_step increment strobe. Channels are independent.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    key_conditioner_if.slave        bus
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_repeat;
    logic [NUM_KEYS-1:0] w_step;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        logic          r_s1;
        logic          r_s2;
        logic [DW-1:0] r_db_cnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;
        logic          r_step;
        state_t        r_state;
        state_t        w_state_nxt;
        logic [RW-1:0] r_rpt_cnt;
        logic [RW-1:0] w_rpt_cnt_nxt;
        logic          w_raw_p;
        logic          w_accept;
        logic          w_rise;
        logic          w_fall;
        logic          w_rpt_fire;

        assign w_raw_p  = ~r_s2;
        // Level change is accepted on the cycle the counter has seen
        // DEBOUNCE_CYCLES-1 prior differing samples and still differs.
        assign w_accept = (w_raw_p != r_level) && (r_db_cnt == DB_LAST);
        assign w_rise   = w_accept &  w_raw_p;
        assign w_fall   = w_accept & ~w_raw_p;

        // Two-flop synchronizer, reset to the released level.
        always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
                r_s1 <= 1'b1;
                r_s2 <= 1'b1;
            end else begin
                r_s1 <= bus.KEY_n[g];
                r_s2 <= r_s1;
            end
        end

        // Debounce counter, accepted level and press/release strobes.
        always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (w_raw_p == r_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_level  <= w_raw_p;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DW'(1);
                end
            end
        end

        // Repeat FSM state, repeat counter and registered repeat/step strobes.
        always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
                r_state   <= ST_IDLE;
                r_rpt_cnt <= '0;
                r_repeat  <= 1'b0;
                r_step    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_rpt_cnt <= w_rpt_cnt_nxt;
                r_repeat  <= w_rpt_fire;
                r_step    <= w_rise | w_rpt_fire;
            end
        end

        // Repeat FSM next state; an accepted release wins over a due repeat.
        always_comb begin
            w_state_nxt   = r_state;
            w_rpt_cnt_nxt = r_rpt_cnt;
            w_rpt_fire    = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt   = ST_DELAY;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                ST_DELAY: begin
                    if (w_fall) begin
                        w_state_nxt   = ST_IDLE;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == DELAY_LAST) begin
                        w_rpt_fire    = 1'b1;
                        w_state_nxt   = ST_REPEAT;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt   = ST_IDLE;
                        w_rpt_cnt_nxt = '0;
                    end else if (r_rpt_cnt == RATE_LAST) begin
                        w_rpt_fire    = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end

        assign w_level[g]   = r_level;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_release;
        assign w_repeat[g]  = r_repeat;
        assign w_step[g]    = r_step;
    end

    assign bus.key_level   = w_level;
    assign bus.key_press   = w_press;
    assign bus.key_release = w_release;
    assign bus.key_repeat  = w_repeat;
    assign bus.key_step    = w_step;

endmodule
